ssled_scan_ctrl: RTL and testbench
==================================

Name: ssled_scan_ctrl

Overview:
- Time-multiplexes NDIG 4-bit digit codes through one shared hex-to-seven-segment decoder.
- Drives the decoder's 4-bit input and an active-low one-hot digit-select bus.
- Inserts an all-off guard interval at each slot change to suppress ghosting.
- Accepts new display contents over a valid/ready handshake and commits them only at frame boundaries, so a frame never shows mixed old/new data.

Parameters:
NDIG, 4, number of multiplexed digits (2..8)
DIV, 50000, clock cycles per digit slot (guard + drive); must exceed BLANK_CYC
BLANK_CYC, 2, all-digits-off guard cycles at start of each slot (0 = no guard)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
en  input  1  scan enable; 0 forces all digits off
ld_valid  input  1  new display contents offered
ld_ready  output  1  controller can accept a load
ld_data  input  4*NDIG  digit codes; digit i = ld_data[4i+3:4i]
ld_blank  input  NDIG  per-digit blank mask, 1 = digit dark
dec_x  output  4  code to shared decoder input
dig_n  output  NDIG  digit select, active-low one-hot
frame_tick  output  1  one-cycle pulse at end of last digit slot

Behaviour:
- All outputs are registered.
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, idx=0, slot counter=0.
  - dig_n=all 1, dec_x=0, ld_ready=1, frame_tick=0.
  - Shadow codes=0, shadow blank=all 1.
  - Pending buffer cleared. A load pending at reset is discarded.
- States: IDLE, GUARD, DRIVE.
- IDLE:
  - dig_n all 1.
  - If en=1: next state GUARD (DRIVE if BLANK_CYC=0), idx=0, cnt=0.
- GUARD:
  - Lasts BLANK_CYC cycles.
  - dig_n all 1. dec_x = shadow code[idx] from the first GUARD cycle.
  - Then go to DRIVE.
- DRIVE:
  - Lasts DIV-BLANK_CYC cycles. dec_x = shadow code[idx].
  - dig_n[idx]=0 unless shadow blank[idx]=1. All other bits are 1.
  - On the last DRIVE cycle, idx advances. It wraps from NDIG-1 to 0.
  - Next state is GUARD (DRIVE if BLANK_CYC=0).
- Frame end is the last DRIVE cycle of idx=NDIG-1.
  - frame_tick=1 in the cycle following it, for exactly one cycle.
  - Frame period = NDIG*DIV cycles.
- en=0 in any state:
  - IDLE next cycle; dig_n all 1 that cycle.
  - idx and cnt cleared. frame_tick not asserted.
  - When en returns, scanning restarts at digit 0 with a full guard.
- Load handshake:
  - A load is accepted on ld_valid & ld_ready.
  - In IDLE, ld_data/ld_blank are written directly to the shadow registers, and ld_ready stays 1.
  - In GUARD/DRIVE:
    - Data goes to the pending buffer, and ld_ready=0 from the next cycle.
    - At the next frame end, pending is copied to shadow. The new contents appear from digit 0 of the following frame.
    - ld_ready returns to 1 in the same cycle frame_tick=1.
  - Acceptance in the frame-end cycle itself: data is applied at the following frame end, not the coincident one.
  - en falling while a load is pending: pending is copied to shadow on entry to IDLE, and ld_ready=1 the next cycle.
  - ld_data is ignored when ld_valid=0 or ld_ready=0.
- Counter widths:
  - cnt: clog2(DIV) bits.
  - idx: clog2(NDIG) bits, minimum 1.
  - No out-of-range idx is ever produced.

Optional Feature:
- Macro: SSLED_SCAN_BLINK_EN.
- When defined:
  - Adds input blink_mask [NDIG-1:0] and parameter BLINK_FRAMES (default 32).
  - A frame counter toggles a blink phase every BLINK_FRAMES frame ends. Phase=0 after reset.
  - During phase 1, digits with blink_mask[i]=1 are treated as blanked.
  - blink_mask is sampled live, not shadowed.
- When not defined: no port, no counter, and behaviour is exactly as above.

Test Plan:
(All scenarios: NDIG=4, DIV=8, BLANK_CYC=2.)
1. Reset: rst_n=0 for 3 cycles with en=1, ld_valid=1 -> dig_n=4'b1111, dec_x=0, ld_ready=1, frame_tick=0 throughout.
2. In IDLE, load ld_data=16'h4321, ld_blank=0, then en=1 -> expected sequence:
   - 2 cycles dig_n=1111 with dec_x=1, then 6 cycles dig_n=1110 with dec_x=1.
   - Digit 1 with dec_x=2, dig_n=1101, and so on.
   - frame_tick pulses once every 32 cycles.
3. Load 16'hABCD while digit 1 is driving -> ld_ready=0 next cycle; digits 2 and 3 still show 3 and 4; ld_ready=1 coincident with frame_tick; next frame digit 0 shows dec_x=D.
4. ld_blank=4'b0100 -> dig_n stays 1111 for the whole digit-2 slot while dec_x=3; other digits are unaffected.
5. en=0 mid-DRIVE of digit 2 -> dig_n=1111 next cycle, no frame_tick; en=1 again -> restart at digit 0 with 2 guard cycles.
6. rst_n=0 with a pending load 16'hABCD -> after reset, shadow=0 and shadow blank=all 1; no digit lights on re-enable until a new load.

Source files
------------

// File: rtl/ssled_scan_if.sv
// Display-load and scan-output bundle for the seven-segment scan controller.
// Defining SSLED_SCAN_BLINK_EN adds the live blink_mask input.
interface ssled_scan_if #(
    parameter int unsigned NDIG = 4
);
    logic                en;
    logic                ld_valid;
    logic                ld_ready;
    logic [4*NDIG-1:0]   ld_data;
    logic [NDIG-1:0]     ld_blank;
    logic [3:0]          dec_x;
    logic [NDIG-1:0]     dig_n;
    logic                frame_tick;
`ifdef SSLED_SCAN_BLINK_EN
    logic [NDIG-1:0]     blink_mask;

    modport master (
        output en, ld_valid, ld_data, ld_blank, blink_mask,
        input  ld_ready, dec_x, dig_n, frame_tick
    );

    modport slave (
        input  en, ld_valid, ld_data, ld_blank, blink_mask,
        output ld_ready, dec_x, dig_n, frame_tick
    );
`else
    modport master (
        output en, ld_valid, ld_data, ld_blank,
        input  ld_ready, dec_x, dig_n, frame_tick
    );

    modport slave (
        input  en, ld_valid, ld_data, ld_blank,
        output ld_ready, dec_x, dig_n, frame_tick
    );
`endif
endinterface

// File: rtl/ssled_scan_ctrl.sv
// Multiplexed seven-segment scan controller: one shared decoder, guard-blanked slots,
// frame-synchronous display loads. Optional blink feature: SSLED_SCAN_BLINK_EN.
module ssled_scan_ctrl #(
    parameter int unsigned NDIG      = 4,
    parameter int unsigned DIV       = 50000,
    parameter int unsigned BLANK_CYC = 2
`ifdef SSLED_SCAN_BLINK_EN
    ,parameter int unsigned BLINK_FRAMES = 32
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    ssled_scan_if.slave bus
);

    localparam int unsigned CNT_W      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned IDX_W      = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int unsigned GUARD_LAST = (BLANK_CYC > 0) ? BLANK_CYC - 1 : 0;

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_GLAST  = CNT_W'(GUARD_LAST);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NDIG - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GUARD = 2'd1;
    localparam logic [1:0] ST_DRIVE = 2'd2;
    // Slot entry state: skip the guard entirely when no blanking is configured
    localparam logic [1:0] ST_SLOT  = (BLANK_CYC > 0) ? ST_GUARD : ST_DRIVE;

`ifdef SSLED_SCAN_BLINK_EN
    localparam int unsigned FR_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FR_W-1:0] FR_LAST = FR_W'(BLINK_FRAMES - 1);
`endif

    logic [1:0]            state_q,        state_d;
    logic [IDX_W-1:0]      idx_q,          idx_d;
    logic [CNT_W-1:0]      cnt_q,          cnt_d;
    logic [NDIG-1:0][3:0]  shadow_code_q,  shadow_code_d;
    logic [NDIG-1:0]       shadow_blank_q, shadow_blank_d;
    logic [NDIG-1:0][3:0]  pend_code_q,    pend_code_d;
    logic [NDIG-1:0]       pend_blank_q,   pend_blank_d;
    logic                  pend_valid_q,   pend_valid_d;
    logic                  ld_ready_q,     ld_ready_d;
    logic [3:0]            dec_x_q,        dec_x_d;
    logic [NDIG-1:0]       dig_n_q,        dig_n_d;
    logic                  frame_tick_q,   frame_tick_d;
    logic [NDIG-1:0]       blank_eff;
    logic                  accept;

`ifdef SSLED_SCAN_BLINK_EN
    logic [FR_W-1:0]       fcnt_q,  fcnt_d;
    logic                  phase_q, phase_d;
`endif

    assign accept = bus.ld_valid & ld_ready_q;

    // Next-state, load routing and output pre-computation
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        cnt_d          = cnt_q;
        shadow_code_d  = shadow_code_q;
        shadow_blank_d = shadow_blank_q;
        pend_code_d    = pend_code_q;
        pend_blank_d   = pend_blank_q;
        pend_valid_d   = pend_valid_q;
        ld_ready_d     = ld_ready_q;
        frame_tick_d   = 1'b0;
        dec_x_d        = 4'h0;
        dig_n_d        = '1;
        blank_eff      = '1;
`ifdef SSLED_SCAN_BLINK_EN
        fcnt_d         = fcnt_q;
        phase_d        = phase_q;
`endif

        if (!bus.en) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            cnt_d   = '0;
            if (pend_valid_q) begin
                shadow_code_d  = pend_code_q;
                shadow_blank_d = pend_blank_q;
                pend_valid_d   = 1'b0;
            end
            if (accept) begin
                shadow_code_d  = bus.ld_data;
                shadow_blank_d = bus.ld_blank;
            end
            ld_ready_d = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        shadow_code_d  = bus.ld_data;
                        shadow_blank_d = bus.ld_blank;
                    end
                    state_d = ST_SLOT;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
                ST_GUARD: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_GLAST) begin
                        state_d = ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_SLOT;
                        idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
                        if (idx_q == IDX_LAST) begin
                            frame_tick_d = 1'b1;
                            // Only a load committed before this cycle is applied here
                            if (pend_valid_q) begin
                                shadow_code_d  = pend_code_q;
                                shadow_blank_d = pend_blank_q;
                                pend_valid_d   = 1'b0;
                                ld_ready_d     = 1'b1;
                            end
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            endcase

            if ((state_q == ST_GUARD || state_q == ST_DRIVE) && accept) begin
                pend_code_d  = bus.ld_data;
                pend_blank_d = bus.ld_blank;
                pend_valid_d = 1'b1;
                ld_ready_d   = 1'b0;
            end
        end

`ifdef SSLED_SCAN_BLINK_EN
        if (frame_tick_d) begin
            if (fcnt_q == FR_LAST) begin
                fcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                fcnt_d = fcnt_q + FR_W'(1);
            end
        end
        blank_eff = shadow_blank_d | (phase_d ? bus.blink_mask : '0);
`else
        blank_eff = shadow_blank_d;
`endif

        // Outputs are aligned with the state they describe
        if (state_d != ST_IDLE) begin
            dec_x_d = shadow_code_d[idx_d];
        end
        if (state_d == ST_DRIVE && !blank_eff[idx_d]) begin
            dig_n_d[idx_d] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            idx_q          <= '0;
            cnt_q          <= '0;
            shadow_code_q  <= '0;
            shadow_blank_q <= '1;
            pend_code_q    <= '0;
            pend_blank_q   <= '0;
            pend_valid_q   <= 1'b0;
            ld_ready_q     <= 1'b1;
            dec_x_q        <= 4'h0;
            dig_n_q        <= '1;
            frame_tick_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            cnt_q          <= cnt_d;
            shadow_code_q  <= shadow_code_d;
            shadow_blank_q <= shadow_blank_d;
            pend_code_q    <= pend_code_d;
            pend_blank_q   <= pend_blank_d;
            pend_valid_q   <= pend_valid_d;
            ld_ready_q     <= ld_ready_d;
            dec_x_q        <= dec_x_d;
            dig_n_q        <= dig_n_d;
            frame_tick_q   <= frame_tick_d;
        end
    end

`ifdef SSLED_SCAN_BLINK_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fcnt_q  <= '0;
            phase_q <= 1'b0;
        end else begin
            fcnt_q  <= fcnt_d;
            phase_q <= phase_d;
        end
    end
`endif

    assign bus.ld_ready   = ld_ready_q;
    assign bus.dec_x      = dec_x_q;
    assign bus.dig_n      = dig_n_q;
    assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_ssled_scan_ctrl.sv
// Directed scoreboard bench for ssled_scan_ctrl (NDIG=4, DIV=8, BLANK_CYC=2).
module tb_ssled_scan_ctrl;

    localparam int unsigned NDIG      = 4;
    localparam int unsigned DIV       = 8;
    localparam int unsigned BLANK_CYC = 2;

    logic clk = 1'b0;
    logic rst_n;

    ssled_scan_if #(.NDIG(NDIG)) bus ();

    ssled_scan_ctrl #(
        .NDIG      (NDIG),
        .DIV       (DIV),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] dig_n;
        logic [3:0] dec_x;
        logic       ready;
        logic       tick;
        int         id;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   step_id  = 0;

    task automatic push_cyc(input int idx, input int cnt, input logic [3:0] code,
                            input bit blanked, input bit ready, input bit tick);
        exp_t e;
        logic [3:0] sel;
        sel = 4'b0001 << idx;
        e.dig_n = (cnt < int'(BLANK_CYC) || blanked) ? 4'b1111 : ~sel;
        e.dec_x = code;
        e.ready = ready;
        e.tick  = tick;
        e.id    = step_id;
        step_id++;
        sb.push_back(e);
    endtask

    task automatic push_off(input bit ready);
        exp_t e;
        e.dig_n = 4'b1111;
        e.dec_x = 4'h0;
        e.ready = ready;
        e.tick  = 1'b0;
        e.id    = step_id;
        step_id++;
        sb.push_back(e);
    endtask

    task automatic push_slot(input int idx, input logic [3:0] code, input bit blanked,
                             input bit ready, input bit tick,
                             input int first = 0, input int last = int'(DIV) - 1);
        for (int c = first; c <= last; c++)
            push_cyc(idx, c, code, blanked, ready, tick && (c == 0));
    endtask

    task automatic push_frame(input logic [15:0] codes, input logic [3:0] blank,
                              input bit ready, input bit tick);
        for (int d = 0; d < int'(NDIG); d++)
            push_slot(d, codes[4*d +: 4], blank[d], ready, tick && (d == 0));
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp, input int id);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s step %0d: observed %h expected %h", tag, id, obs, exp);
        end
    endtask

    task automatic check_cycles(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                n_assert++;
                n_fail++;
                $error("FAIL scoreboard_empty: observed 0 entries expected 1");
            end else begin
                e = sb.pop_front();
                chk("dig_n",      bus.dig_n,              e.dig_n,          e.id);
                chk("dec_x",      bus.dec_x,              e.dec_x,          e.id);
                chk("ld_ready",   {3'b000, bus.ld_ready}, {3'b000, e.ready}, e.id);
                chk("frame_tick", {3'b000, bus.frame_tick}, {3'b000, e.tick}, e.id);
            end
        end
    endtask

    task automatic load_pulse(input logic [15:0] data, input logic [3:0] blank);
        bus.ld_data  = data;
        bus.ld_blank = blank;
        bus.ld_valid = 1'b1;
        check_cycles(1);
        bus.ld_valid = 1'b0;
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.en       = 1'b1;
        bus.ld_valid = 1'b1;
        bus.ld_data  = 16'hABCD;
        bus.ld_blank = 4'b0000;
`ifdef SSLED_SCAN_BLINK_EN
        bus.blink_mask = '0;
`endif

        // Reset with en and a load offered
        repeat (3) push_off(1'b1);
        check_cycles(3);
        rst_n        = 1'b1;
        bus.en       = 1'b0;
        bus.ld_valid = 1'b0;

        // Direct load in IDLE, then start scanning
        push_off(1'b1);
        load_pulse(16'h4321, 4'b0000);
        bus.en = 1'b1;
        push_frame(16'h4321, 4'b0000, 1'b1, 1'b0);
        check_cycles(32);

        // Load during digit 1 drive, applied from next frame
        push_slot(0, 4'h1, 1'b0, 1'b1, 1'b1);
        check_cycles(8);
        push_slot(1, 4'h2, 1'b0, 1'b1, 1'b0, 0, 2);
        check_cycles(3);
        push_slot(1, 4'h2, 1'b0, 1'b0, 1'b0, 3, 7);
        load_pulse(16'hABCD, 4'b0000);
        check_cycles(4);
        push_slot(2, 4'h3, 1'b0, 1'b0, 1'b0);
        push_slot(3, 4'h4, 1'b0, 1'b0, 1'b0);
        check_cycles(16);
        push_slot(0, 4'hD, 1'b0, 1'b1, 1'b1);
        check_cycles(8);

        // Blank mask on digit 2
        push_slot(1, 4'hC, 1'b0, 1'b0, 1'b0);
        load_pulse(16'h4321, 4'b0100);
        check_cycles(7);
        push_slot(2, 4'hB, 1'b0, 1'b0, 1'b0);
        push_slot(3, 4'hA, 1'b0, 1'b0, 1'b0);
        check_cycles(16);
        push_slot(0, 4'h1, 1'b0, 1'b1, 1'b1);
        check_cycles(8);
        push_slot(1, 4'h2, 1'b0, 1'b0, 1'b0);
        load_pulse(16'h4321, 4'b0000);
        check_cycles(7);
        push_slot(2, 4'h3, 1'b1, 1'b0, 1'b0);
        push_slot(3, 4'h4, 1'b0, 1'b0, 1'b0);
        check_cycles(16);

        // en drop mid-drive of digit 2, then restart
        push_slot(0, 4'h1, 1'b0, 1'b1, 1'b1);
        push_slot(1, 4'h2, 1'b0, 1'b1, 1'b0);
        push_slot(2, 4'h3, 1'b0, 1'b1, 1'b0, 0, 3);
        check_cycles(20);
        bus.en = 1'b0;
        repeat (4) push_off(1'b1);
        check_cycles(4);
        bus.en = 1'b1;
        push_frame(16'h4321, 4'b0000, 1'b1, 1'b0);
        check_cycles(32);
        push_slot(0, 4'h1, 1'b0, 1'b1, 1'b1);
        check_cycles(8);

        // Reset with a pending load discards it
        push_slot(1, 4'h2, 1'b0, 1'b0, 1'b0);
        load_pulse(16'hABCD, 4'b0000);
        check_cycles(7);
        rst_n = 1'b0;
        repeat (2) push_off(1'b1);
        check_cycles(2);
        rst_n = 1'b1;
        push_frame(16'h0000, 4'b1111, 1'b1, 1'b0);
        check_cycles(32);
        push_slot(0, 4'h0, 1'b1, 1'b1, 1'b1);
        check_cycles(8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
